fifo_byte_drain: RTL and testbench



---
 rtl/fifo_byte_drain.sv | 118 +++++++++++
 tb/tb_fifo_byte_drain.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_drain.sv
// fifo_byte_drain: pops 36-bit words from a first-word-fall-through FIFO in
// bursts and serialises each word little-endian into five bytes on a
// valid/ready byte stream. Bursts start when the FIFO is above its
// almost-empty mark, or when a flush timer expires with data still waiting.
module fifo_byte_drain #(
  parameter int unsigned BURST_WORDS  = 16,
  parameter int unsigned FLUSH_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [35:0] DO,
  input  logic        EMPTY,
  input  logic        ALMOSTEMPTY,
  output logic        RDEN,
  output logic [7:0]  BYTE,
  output logic        BVALID,
  input  logic        BREADY,
  output logic        BUSY
);

  localparam int unsigned TW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned CW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [TW-1:0] TIMER_MAX  = TW'(FLUSH_CYCLES);
  localparam logic [CW-1:0] COUNT_INIT = CW'(BURST_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [35:0]     shift;
  logic [2:0]      idx;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   timer;
  logic            start;
  logic            next_word;
  logic            advance;

  // Next-state and pop decisions; the pop strobe is combinational so the
  // FWFT word on DO is consumed in the same cycle it is captured.
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    next_word = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY && (!ALMOSTEMPTY || timer == TIMER_MAX)) begin
          start   = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (BREADY) begin
          if (idx != 3'd4) begin
            advance = 1'b1;
          end else if (cnt != '0 && !EMPTY) begin
            next_word = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    RDEN = RSTN & (start | next_word);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Word capture, byte shifting, byte index and burst word counter.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      shift <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else if (start) begin
      shift <= DO;
      idx   <= '0;
      cnt   <= COUNT_INIT;
    end else if (next_word) begin
      shift <= DO;
      idx   <= '0;
      cnt   <= cnt - CW'(1);
    end else if (advance) begin
      shift <= {8'h00, shift[35:8]};
      idx   <= idx + 3'd1;
    end
  end

  // Flush timer: counts idle cycles with data held back by ALMOSTEMPTY.
  // It is cleared on start and therefore reads zero throughout a burst.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      timer <= '0;
    end else if (state == IDLE) begin
      if (start || EMPTY) begin
        timer <= '0;
      end else if (ALMOSTEMPTY && timer != TIMER_MAX) begin
        timer <= timer + TW'(1);
      end
    end
  end

  assign BYTE   = shift[7:0];
  assign BVALID = (state == SEND);
  assign BUSY   = (state == SEND);

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Directed bench for fifo_byte_drain with a behavioural FWFT FIFO model.
module tb_fifo_byte_drain;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [35:0] DO = '0;
  logic        EMPTY = 1'b1;
  logic        ALMOSTEMPTY = 1'b1;
  logic        RDEN;
  logic [7:0]  BYTE;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic        BUSY;

  fifo_byte_drain #(.BURST_WORDS(4), .FLUSH_CYCLES(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .DO(DO), .EMPTY(EMPTY), .ALMOSTEMPTY(ALMOSTEMPTY),
    .RDEN(RDEN), .BYTE(BYTE), .BVALID(BVALID), .BREADY(BREADY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [35:0] fq[$];
  logic [7:0]  got[$];
  int          runs[$];
  int          ae_mode = 1;   // 0: AE low, 1: AE high, 2: AE when <=2 words
  int          rden_cnt = 0;
  int          busy_cnt = 0;
  int          viol = 0;
  int          run_len = 0;
  int          checks = 0;
  int          passes = 0;
  logic        prev_rden = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = '0;

  // FIFO model: pop on RDEN, flags registered from post-pop occupancy.
  always @(posedge CLK) begin
    if (RSTN && RDEN && fq.size() > 0) void'(fq.pop_front());
    EMPTY       <= (fq.size() == 0);
    DO          <= (fq.size() > 0) ? fq[0] : 36'h0;
    ALMOSTEMPTY <= (ae_mode == 0) ? 1'b0 : (ae_mode == 1) ? 1'b1 : (fq.size() <= 2);
  end

  // Stream monitor: collects handshaken bytes, burst lengths, protocol violations.
  always @(posedge CLK) begin
    if (!RSTN) begin
      prev_rden  = 1'b0;
      prev_stall = 1'b0;
      run_len    = 0;
    end else begin
      if (BVALID && BREADY) got.push_back(BYTE);
      if (RDEN) rden_cnt++;
      if (BUSY) busy_cnt++;
      if (RDEN && EMPTY) viol++;
      if (RDEN && prev_rden) viol++;
      if (prev_stall && (!BVALID || BYTE !== prev_byte)) viol++;
      if (BVALID) run_len++;
      else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end
      prev_rden  = RDEN;
      prev_stall = BVALID && !BREADY;
      prev_byte  = BYTE;
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic clr();
    got.delete(); runs.delete();
    rden_cnt = 0; busy_cnt = 0; viol = 0;
  endtask

  task automatic wait_done(input int unsigned max);
    bit ok = 1'b0;
    for (int unsigned i = 0; i < max; i++) begin
      step();
      if (fq.size() == 0 && EMPTY && !BVALID && !BUSY) begin ok = 1'b1; break; end
    end
    step(); step();
    checks++;
    if (!ok) $display("FAIL done_timeout: stream still active after %0d cycles, required idle", max);
    else passes++;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; BREADY = 1'b0; ae_mode = 1;
    repeat (3) step();
    checks++; if (RDEN !== 1'b0) $display("FAIL reset_rden: got %b want 0", RDEN); else passes++;
    checks++; if (BVALID !== 1'b0) $display("FAIL reset_bvalid: got %b want 0", BVALID); else passes++;
    checks++; if (BYTE !== 8'h00) $display("FAIL reset_byte: got %h want 00", BYTE); else passes++;
    checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else passes++;
    RSTN = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [7:0] e[5] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0A};
    clr(); ae_mode = 0; BREADY = 1'b1;
    fq.push_back(36'hA_1234_5678);
    wait_done(40);
    checks++; if (got.size() != 5) $display("FAIL single_count: got %0d bytes want 5", got.size()); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== e[k]) $display("FAIL single_byte%0d: got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
      else passes++;
    end
    checks++; if (rden_cnt != 1) $display("FAIL single_rden: got %0d pulses want 1", rden_cnt); else passes++;
    checks++; if (busy_cnt != 5) $display("FAIL single_busy: got %0d cycles want 5", busy_cnt); else passes++;
    checks++; if (viol != 0) $display("FAIL single_protocol: got %0d violations want 0", viol); else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0] e[5] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0A};
    bit ok = 1'b0;
    clr(); ae_mode = 0;
    fq.push_back(36'hA_1234_5678);
    for (int i = 0; i < 80; i++) begin
      BREADY = (i % 4 == 0) || (i % 4 == 3);
      step();
      if (got.size() == 5 && !BVALID && fq.size() == 0) begin ok = 1'b1; break; end
    end
    BREADY = 1'b1;
    step(); step();
    checks++; if (!ok) $display("FAIL bp_timeout: got %0d bytes want 5", got.size()); else passes++;
    checks++; if (got.size() != 5) $display("FAIL bp_handshakes: got %0d want 5", got.size()); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== e[k]) $display("FAIL bp_byte%0d: got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
      else passes++;
    end
    checks++; if (rden_cnt != 1) $display("FAIL bp_rden: got %0d pulses want 1", rden_cnt); else passes++;
    checks++; if (viol != 0) $display("FAIL bp_stability: got %0d violations want 0", viol); else passes++;
  endtask

  task automatic test_flush();
    logic [7:0] e[10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 8'h55, 8'h66, 8'h77, 8'h88, 8'h07};
    ae_mode = 1; BREADY = 1'b1;
    for (int r = 0; r < 2; r++) begin
      int idle = 0;
      bit hit = 1'b0;
      clr();
      fq.push_back(36'h3_4433_2211);
      fq.push_back(36'h7_8877_6655);
      for (int i = 0; i < 40; i++) begin
        step();
        if (RDEN) begin hit = 1'b1; break; end
        if (!EMPTY) idle++;
      end
      checks++; if (!hit || idle != 8) $display("FAIL flush_wait run%0d: got %0d idle cycles (pop seen %b) want 8", r, idle, hit); else passes++;
      wait_done(60);
      checks++; if (got.size() != 10) $display("FAIL flush_count run%0d: got %0d bytes want 10", r, got.size()); else passes++;
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (k >= got.size() || got[k] !== e[k]) $display("FAIL flush_byte%0d run%0d: got %h want %h", k, r, (k < got.size()) ? got[k] : 8'hxx, e[k]);
        else passes++;
      end
      checks++; if (rden_cnt != 2) $display("FAIL flush_rden run%0d: got %0d want 2", r, rden_cnt); else passes++;
      checks++; if (viol != 0) $display("FAIL flush_protocol run%0d: got %0d want 0", r, viol); else passes++;
    end
  endtask

  task automatic test_burst_limit();
    int bad = 0;
    clr(); ae_mode = 2; BREADY = 1'b1;
    for (int i = 0; i < 10; i++)
      fq.push_back({4'(i), 8'(8*i+4), 8'(8*i+3), 8'(8*i+2), 8'(8*i+1)});
    wait_done(300);
    checks++; if (got.size() != 50) $display("FAIL burst_count: got %0d bytes want 50", got.size()); else passes++;
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 5; k++)
        if (5*i+k >= got.size() || got[5*i+k] !== ((k < 4) ? 8'(8*i+k+1) : 8'(i))) bad++;
    checks++; if (bad != 0) $display("FAIL burst_bytes: got %0d wrong bytes want 0", bad); else passes++;
    checks++; if (runs.size() != 3) $display("FAIL burst_runs: got %0d bursts want 3", runs.size()); else passes++;
    checks++;
    if (runs.size() != 3 || runs[0] != 20 || runs[1] != 20 || runs[2] != 10)
      $display("FAIL burst_lengths: got %p want 20,20,10", runs);
    else passes++;
    checks++; if (rden_cnt != 10) $display("FAIL burst_rden: got %0d want 10", rden_cnt); else passes++;
    checks++; if (viol != 0) $display("FAIL burst_protocol: got %0d want 0", viol); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e[5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h01};
    bit ok = 1'b0;
    clr(); ae_mode = 0; BREADY = 1'b1;
    fq.push_back(36'h9_DDCC_BBAA);
    fq.push_back(36'h1_5544_3322);
    for (int i = 0; i < 30; i++) begin
      step();
      if (got.size() == 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || BYTE !== 8'hCC) $display("FAIL rstmid_byte2: got %h (reached %b) want cc", BYTE, ok); else passes++;
    RSTN = 1'b0;
    step();
    checks++; if (BVALID !== 1'b0) $display("FAIL rstmid_bvalid: got %b want 0", BVALID); else passes++;
    checks++; if (RDEN !== 1'b0) $display("FAIL rstmid_rden: got %b want 0", RDEN); else passes++;
    checks++; if (BUSY !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", BUSY); else passes++;
    checks++; if (BYTE !== 8'h00) $display("FAIL rstmid_bytereg: got %h want 00", BYTE); else passes++;
    RSTN = 1'b1;
    clr();
    wait_done(40);
    checks++; if (got.size() != 5) $display("FAIL rstmid_count: got %0d bytes want 5", got.size()); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== e[k]) $display("FAIL rstmid_byte%0d: got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
      else passes++;
    end
    checks++; if (rden_cnt != 1) $display("FAIL rstmid_rden_after: got %0d want 1", rden_cnt); else passes++;
  endtask

  task automatic test_empty_mid();
    logic [7:0] e[5] = '{8'hEF, 8'hBE, 8'hFE, 8'hCA, 8'h06};
    clr(); ae_mode = 0; BREADY = 1'b1;
    fq.push_back(36'h6_CAFE_BEEF);
    wait_done(40);
    checks++; if (rden_cnt != 1) $display("FAIL empty_rden: got %0d want 1", rden_cnt); else passes++;
    checks++; if (runs.size() != 1 || runs[0] != 5) $display("FAIL empty_run: got %p want 5", runs); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== e[k]) $display("FAIL empty_byte%0d: got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
      else passes++;
    end
    clr(); ae_mode = 1;
    fq.push_back(36'h6_CAFE_BEEF);
    repeat (5) step();
    checks++; if (rden_cnt != 0) $display("FAIL empty_nostart: got %0d pops want 0", rden_cnt); else passes++;
    ae_mode = 0;
    wait_done(40);
    checks++; if (rden_cnt != 1) $display("FAIL empty_restart: got %0d pops want 1", rden_cnt); else passes++;
    checks++; if (got.size() != 5) $display("FAIL empty_restart_count: got %0d want 5", got.size()); else passes++;
    checks++; if (viol != 0) $display("FAIL empty_protocol: got %0d want 0", viol); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_burst_limit();
    test_reset_mid();
    test_empty_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
